// File: rtl/lzc_norm_seq.sv
// lzc_norm_seq: multi-cycle leading-zero normalizer.
// The operand is scanned one CHUNK-bit slice per cycle from the MSB end.
// Each all-zero slice is shifted out whole. The first non-zero slice gets a
// narrow lzc that finishes the normalization in the same cycle.
module lzc_norm_seq #(
  parameter  int WIDTH = 64,
  parameter  int CHUNK = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic             r_zero;

  logic [CHUNK-1:0] w_top;
  logic [CW-1:0]    w_z;
  logic             w_found;

  assign w_top = r_sreg[WIDTH-1 -: CHUNK];

  // Narrow leading-zero count of the top slice. The result is only used when
  // the slice is non-zero, so the all-zero encoding does not matter.
  always_comb begin
    w_z     = '0;
    w_found = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!w_found && w_top[i]) begin
        w_z     = CW'(CHUNK - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  // Control FSM and datapath. Flush drops any operand that is in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_zero  <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sreg  <= in_data;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_zero  <= 1'b0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_top != '0) begin
            r_sreg  <= r_sreg << w_z;
            r_cnt   <= r_cnt + w_z;
            r_state <= DONE;
          end else if (r_idx == IW'(NCH - 1)) begin
            // The last slice is zero as well, so the operand was all zeros.
            r_sreg  <= '0;
            r_cnt   <= CW'(WIDTH);
            r_zero  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_sreg <= r_sreg << CHUNK;
            r_cnt  <= r_cnt + CW'(CHUNK);
            r_idx  <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The handshake flags are pure state decodes. The result stays frozen in
  // sreg/cnt/zero while DONE.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_sreg;
  assign out_count = r_cnt;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_lzc_norm_seq.sv
// Bench for lzc_norm_seq: a constant table, hand-written flush/reset
// sequences, and random operands checked against a full-width lzc model.
module tb_lzc_norm_seq;
  localparam int W   = 64;
  localparam int C   = 16;
  localparam int NCH = W / C;
  localparam int CW  = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_zero;

  int total = 0;
  int bad   = 0;

  lzc_norm_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           cnt;
    logic [W-1:0] q;
    logic         z;
    int           s;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference leading-zero count: walk down from the MSB.
  function automatic int ref_lz(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return W - 1 - i;
    return W;
  endfunction

  // Offer one operand, then count the edges until out_valid rises.
  // in_ready must stay low for every cycle of the scan.
  task automatic run_op(input logic [W-1:0] d, output int lat);
    @(negedge clk);
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;   // must not affect the result after the accepting edge
    lat = 0;
    do begin
      if (!out_valid) chk("ready_low_in_scan", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ready_after_hs", 64'(in_ready), 64'd1);
    chk("valid_after_hs", 64'(out_valid), 64'd0);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    int lat;
    run_op(v.d, lat);
    chk({tag, "_count"}, 64'(out_count), 64'(v.cnt));
    chk({tag, "_data"},  out_data,       v.q);
    chk({tag, "_zero"},  64'(out_zero),  64'(v.z));
    chk({tag, "_lat"},   64'(lat),       64'(v.s));
    finish_op();
  endtask

  task automatic check_model(input logic [W-1:0] d);
    vec_t v;
    int   lz;
    lz    = ref_lz(d);
    v.d   = d;
    v.cnt = lz;
    v.q   = (lz >= W) ? '0 : (d << lz);
    v.z   = (d == '0);
    v.s   = (lz / C + 1 < NCH) ? lz / C + 1 : NCH;
    check_vec("rnd", v);
  endtask

  initial begin
    int           lat;
    logic [W-1:0] hold_d;
    logic [CW-1:0] hold_c;
    logic [63:0]  r;

    tbl[0] = '{64'h8000_0000_0000_0001,  0, 64'h8000_0000_0000_0001, 1'b0, 1};
    tbl[1] = '{64'h0000_0000_0001_0000, 47, 64'h8000_0000_0000_0000, 1'b0, 3};
    tbl[2] = '{64'h0000_0000_0000_0000, 64, 64'h0000_0000_0000_0000, 1'b1, 4};
    tbl[3] = '{64'h0000_0000_0000_0001, 63, 64'h8000_0000_0000_0000, 1'b0, 4};
    tbl[4] = '{64'h0000_8000_0000_0000, 16, 64'h8000_0000_0000_0000, 1'b0, 2};
    tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF,  1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1};
    tbl[6] = '{64'h0000_0000_0000_FFFF, 48, 64'hFFFF_0000_0000_0000, 1'b0, 4};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready),  64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_data",  out_data,       64'd0);
    chk("rst_zero",  64'(out_zero),  64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) check_vec($sformatf("tbl%0d", i), tbl[i]);

    // Backpressure: the result stays frozen, then a flush discards it.
    run_op(64'h0000_0001_0000_0000, lat);
    hold_d = out_data;
    hold_c = out_count;
    chk("bp_count", 64'(out_count), 64'd31);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data",  out_data,       hold_d);
      chk("bp_cnt",   64'(out_count), 64'(hold_c));
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    check_vec("after_flush", '{64'h0000_0000_0000_0003, 62, 64'hC000_0000_0000_0000, 1'b0, 4});

    // A flush on the same edge as an offered operand wins; nothing is accepted.
    @(negedge clk);
    in_data = 64'h5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc_ready", 64'(in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("flush_acc_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    in_data = 64'h0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_ready", 64'(in_ready),  64'd1);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(out_count), 64'd0);
    chk("arst_data",  out_data,       64'd0);
    @(negedge clk);
    resetn = 1'b1;
    check_vec("post_arst", tbl[1]);

    // Random regression against the full-width model.
    for (int n = 0; n < 2000; n++) begin
      r = {$urandom, $urandom};
      check_model({1'b1, r[62:0]} >> $urandom_range(0, 64));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
